// File: rtl/vx_tb_mem_load_arb_if.sv
// Load request and beat stream bundle for vx_tb_mem_load_arb.
// Masters present lines and take beats; the arbiter is the slave.
interface vx_tb_mem_load_arb_if #(
  parameter int NUM_CH = 4,
  parameter int LINE_W = 512,
  parameter int WORD_W = 32,
  parameter int TYPE_W = 3
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]        load_valid;
  logic [NUM_CH-1:0]        load_ready;
  logic [NUM_CH*TYPE_W-1:0] data_type;
  logic [NUM_CH*LINE_W-1:0] cacheline;
  logic                     out_valid;
  logic                     out_ready;
  logic [WORD_W-1:0]        out_word;
  logic [TYPE_W-1:0]        out_type;
  logic [CH_W-1:0]          out_ch;
  logic                     out_first;
  logic                     out_last;
  logic                     busy;

  modport master (
    output load_valid, data_type, cacheline, out_ready,
    input  load_ready, out_valid, out_word, out_type,
    input  out_ch, out_first, out_last, busy
  );

  modport slave (
    input  load_valid, data_type, cacheline, out_ready,
    output load_ready, out_valid, out_word, out_type,
    output out_ch, out_first, out_last, busy
  );
endinterface

// File: rtl/vx_tb_mem_load_arb.sv
// Round-robin load arbiter with line FIFO and word serialiser.
// Lines leave in acceptance order, low word first.
module vx_tb_mem_load_arb #(
  parameter int NUM_CH     = 4,
  parameter int LINE_W     = 512,
  parameter int WORD_W     = 32,
  parameter int TYPE_W     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input logic                 clk,
  input logic                 reset,
  vx_tb_mem_load_arb_if.slave bus
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int BEATS = LINE_W / WORD_W;
  localparam int BT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PT_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {IDLE, STREAM} state_e;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [TYPE_W-1:0] dtype;
    logic [LINE_W-1:0] line;
  } entry_t;

  entry_t            mem_q [FIFO_DEPTH];
  entry_t            cur_q, cur_d;
  entry_t            push_e;
  state_e            state_q, state_d;
  logic [PT_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PT_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BT_W-1:0]   beat_q, beat_d;

  logic              full, empty, stream;
  logic              grant_vld, push, pop;
  logic              fire, last;
  logic [CH_W-1:0]   grant_idx;
  logic [CH_W:0]     scan;

  // Scan from rr_ptr upward, wrapping, and take the first valid.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
      if (scan >= (CH_W+1)'(NUM_CH))
        scan = scan - (CH_W+1)'(NUM_CH);
      if (!grant_vld && bus.load_valid[scan[CH_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = scan[CH_W-1:0];
      end
    end
  end

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign push   = grant_vld && !full;
  assign stream = (state_q == STREAM);
  assign last   = (beat_q == BT_W'(BEATS - 1));
  assign fire   = stream && bus.out_ready;
  assign pop    = !empty && (!stream || (fire && last));

  always_comb begin
    bus.load_ready = '0;
    if (push) bus.load_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    push_e       = '0;
    push_e.ch    = grant_idx;
    push_e.dtype = bus.data_type[grant_idx*TYPE_W +: TYPE_W];
    push_e.line  = bus.cacheline[grant_idx*LINE_W +: LINE_W];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PT_W'(1);
      rr_ptr_d = (grant_idx == CH_W'(NUM_CH - 1)) ?
                 '0 : grant_idx + CH_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PT_W'(1);
    if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
    else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
  end

  // The line register shifts right so the live beat is always word 0.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cur_d   = cur_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          cur_d   = mem_q[rd_ptr_q];
          beat_d  = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (fire) begin
          if (!last) begin
            beat_d     = beat_q + BT_W'(1);
            cur_d.line = cur_q.line >> WORD_W;
          end else if (pop) begin
            cur_d  = mem_q[rd_ptr_q];
            beat_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_e;
    cur_q <= cur_d;
  end

  assign bus.out_valid = stream;
  assign bus.out_word  = cur_q.line[WORD_W-1:0];
  assign bus.out_type  = cur_q.dtype;
  assign bus.out_ch    = cur_q.ch;
  assign bus.out_first = stream && (beat_q == '0);
  assign bus.out_last  = stream && last;
  assign bus.busy      = !empty || stream;
endmodule

// File: tb/tb_vx_tb_mem_load_arb.sv
// Directed bench for vx_tb_mem_load_arb.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_vx_tb_mem_load_arb;
  localparam int NUM_CH = 4;
  localparam int LINE_W = 512;
  localparam int WORD_W = 32;
  localparam int TYPE_W = 3;
  localparam int FDEPTH = 4;
  localparam int BEATS  = 16;

  typedef struct {
    int          ch;
    logic [31:0] word;
    logic [2:0]  dtype;
    logic        first;
    logic        last;
    int          cyc;
  } beat_t;

  typedef struct {
    int          ch;
    logic [31:0] base;
    logic [2:0]  dtype;
    int          cyc;
  } acc_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vx_tb_mem_load_arb_if #(
    .NUM_CH(NUM_CH), .LINE_W(LINE_W),
    .WORD_W(WORD_W), .TYPE_W(TYPE_W)
  ) bus ();

  vx_tb_mem_load_arb #(
    .NUM_CH(NUM_CH), .LINE_W(LINE_W), .WORD_W(WORD_W),
    .TYPE_W(TYPE_W), .FIFO_DEPTH(FDEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  beat_t       beats[$];
  acc_t        accs[$];
  logic [31:0] cur_base [NUM_CH];
  logic [2:0]  cur_type [NUM_CH];
  int          tests = 0;
  int          fails = 0;
  int          cyc_n = 0;
  logic [NUM_CH-1:0] rdy_s;
  logic        ov_s;
  logic [31:0] ow_s;
  logic        busy_s;

  task automatic set_line(input int c, input logic [31:0] base,
                          input logic [2:0] t);
    logic [LINE_W-1:0] l;
    l = '0;
    for (int w = 0; w < BEATS; w++)
      l[w*WORD_W +: WORD_W] = base + 32'(w);
    bus.cacheline[c*LINE_W +: LINE_W] = l;
    bus.data_type[c*TYPE_W +: TYPE_W] = t;
    cur_base[c] = base;
    cur_type[c] = t;
  endtask

  task automatic init_lines();
    for (int c = 0; c < NUM_CH; c++)
      set_line(c, {8'(c + 1), 24'h0}, 3'(c));
  endtask

  // One cycle: sample, log handshakes, advance to the next falling edge.
  task automatic step();
    int    g;
    beat_t b;
    acc_t  a;
    g = -1;
    #1;
    rdy_s  = bus.load_ready;
    ov_s   = bus.out_valid;
    ow_s   = bus.out_word;
    busy_s = bus.busy;
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++)
        if (bus.load_ready[c] && bus.load_valid[c]) begin
          g = c;
          a = '{c, cur_base[c], cur_type[c], cyc_n};
          accs.push_back(a);
        end
      if (bus.out_valid && bus.out_ready) begin
        b = '{int'(bus.out_ch), bus.out_word, bus.out_type,
              bus.out_first, bus.out_last, cyc_n};
        beats.push_back(b);
      end
    end
    @(negedge clk);
    cyc_n++;
    if (g >= 0)
      set_line(g, cur_base[g] + 32'h0001_0000, cur_type[g] + 3'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.load_valid = '0;
    bus.out_ready = 1'b0;
    init_lines();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    beats.delete();
    accs.delete();
    cyc_n = 0;
  endtask

  task automatic drain(input int maxc, output bit to);
    int n;
    n = 0;
    while (bus.busy && n < maxc) begin
      step();
      n++;
    end
    to = bus.busy;
  endtask

  // Beats expected from the accepted-line log, in acceptance order.
  function automatic int sb_errs();
    int n;
    n = 0;
    if (beats.size() != accs.size() * BEATS) return -1;
    for (int i = 0; i < beats.size(); i++) begin
      acc_t a;
      int   w;
      a = accs[i / BEATS];
      w = i % BEATS;
      if (beats[i].ch != a.ch ||
          beats[i].word !== a.base + 32'(w) ||
          beats[i].dtype !== a.dtype ||
          beats[i].first !== (w == 0) ||
          beats[i].last !== (w == BEATS - 1))
        n++;
    end
    return n;
  endfunction

  task automatic test_reset();
    do_reset();
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_out: valid=%b busy=%b want 0 0",
               bus.out_valid, bus.busy);
    end
    tests++;
    if (bus.load_ready !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ready: got %b want 0000", bus.load_ready);
    end
    bus.load_valid = 4'b1111;
    #1;
    tests++;
    if (bus.load_ready !== 4'b0001) begin
      fails++;
      $display("FAIL reset_grant: got %b want 0001", bus.load_ready);
    end
    bus.load_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit to;
    do_reset();
    set_line(2, 32'h0, 3'd3);
    bus.load_valid = 4'b0100;
    bus.out_ready = 1'b1;
    step();
    tests++;
    if (rdy_s !== 4'b0100) begin
      fails++;
      $display("FAIL single_ready: got %b want 0100", rdy_s);
    end
    bus.load_valid = '0;
    drain(40, to);
    tests++;
    if (to) begin
      fails++;
      $display("FAIL single_timeout: busy=1 want 0");
    end
    tests++;
    if (beats.size() != 16) begin
      fails++;
      $display("FAIL single_count: got %0d want 16", beats.size());
    end
    tests++;
    if (beats.size() > 0 && (beats[0].cyc != 2 || beats[0].ch != 2 ||
        beats[0].dtype !== 3'd3 || beats[0].word !== 32'd0)) begin
      fails++;
      $display("FAIL single_first: cyc=%0d ch=%0d type=%0d word=%0h want 2 2 3 0",
               beats[0].cyc, beats[0].ch, beats[0].dtype, beats[0].word);
    end
    tests++;
    if (beats.size() == 16 && (beats[15].word !== 32'd15 ||
        beats[15].last !== 1'b1 || beats[15].cyc != 17)) begin
      fails++;
      $display("FAIL single_last: word=%0h last=%b cyc=%0d want f 1 17",
               beats[15].word, beats[15].last, beats[15].cyc);
    end
    tests++;
    if (sb_errs() != 0) begin
      fails++;
      $display("FAIL single_data: %0d bad beats want 0", sb_errs());
    end
  endtask

  task automatic test_rr();
    bit to;
    int bad;
    do_reset();
    bus.load_valid = 4'b1111;
    bus.out_ready = 1'b1;
    repeat (60) step();
    bus.load_valid = '0;
    drain(200, to);
    tests++;
    if (to) begin
      fails++;
      $display("FAIL rr_timeout: busy=1 want 0");
    end
    tests++;
    if (accs.size() != 8) begin
      fails++;
      $display("FAIL rr_grants: got %0d want 8", accs.size());
    end
    bad = 0;
    foreach (accs[i]) if (accs[i].ch != i % NUM_CH) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL rr_order: %0d out-of-order grants want 0", bad);
    end
    tests++;
    if (accs.size() > 5 && accs[5].cyc != 18) begin
      fails++;
      $display("FAIL rr_nobypass: 6th grant cyc=%0d want 18", accs[5].cyc);
    end
    tests++;
    if (sb_errs() != 0) begin
      fails++;
      $display("FAIL rr_data: %0d bad beats want 0", sb_errs());
    end
  endtask

  task automatic test_full();
    bit to;
    int bad;
    do_reset();
    bus.load_valid = 4'b1111;
    bus.out_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i >= 2 && (ov_s !== 1'b1 || ow_s !== 32'h0100_0000)) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL full_stable: %0d unstable cycles want 0", bad);
    end
    tests++;
    if (accs.size() != FDEPTH + 1) begin
      fails++;
      $display("FAIL full_accepts: got %0d want %0d",
               accs.size(), FDEPTH + 1);
    end
    tests++;
    if (rdy_s !== 4'b0000 || busy_s !== 1'b1) begin
      fails++;
      $display("FAIL full_refuse: ready=%b busy=%b want 0000 1",
               rdy_s, busy_s);
    end
    bus.load_valid = '0;
    bus.out_ready = 1'b1;
    drain(200, to);
    tests++;
    if (to) begin
      fails++;
      $display("FAIL full_timeout: busy=1 want 0");
    end
    tests++;
    if (beats.size() != 80) begin
      fails++;
      $display("FAIL full_count: got %0d want 80", beats.size());
    end
    tests++;
    if (sb_errs() != 0) begin
      fails++;
      $display("FAIL full_order: %0d bad beats want 0", sb_errs());
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int bad;
    do_reset();
    bus.out_ready = 1'b0;
    bus.load_valid = 4'b0001;
    step();
    bus.load_valid = 4'b0010;
    step();
    bus.load_valid = '0;
    bus.out_ready = 1'b1;
    drain(100, to);
    tests++;
    if (to || beats.size() != 32) begin
      fails++;
      $display("FAIL b2b_count: got %0d timeout=%b want 32 0",
               beats.size(), to);
    end
    bad = 0;
    foreach (beats[i]) if (beats[i].cyc != 2 + i) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL b2b_bubble: %0d gapped beats want 0", bad);
    end
    tests++;
    if (beats.size() == 32 &&
        (beats[15].last !== 1'b1 || beats[31].last !== 1'b1 ||
         beats[16].first !== 1'b1)) begin
      fails++;
      $display("FAIL b2b_flags: last15=%b last31=%b first16=%b want 1 1 1",
               beats[15].last, beats[31].last, beats[16].first);
    end
    tests++;
    if (sb_errs() != 0) begin
      fails++;
      $display("FAIL b2b_data: %0d bad beats want 0", sb_errs());
    end
  endtask

  task automatic test_stall();
    bit to;
    int n;
    int bad;
    do_reset();
    bus.load_valid = 4'b0010;
    bus.out_ready = 1'b1;
    step();
    bus.load_valid = '0;
    n = 0;
    while (beats.size() < 5 && n < 50) begin
      step();
      n++;
    end
    tests++;
    if (beats.size() != 5) begin
      fails++;
      $display("FAIL stall_reach: got %0d beats want 5", beats.size());
    end
    bus.out_ready = 1'b0;
    bad = 0;
    repeat (3) begin
      step();
      if (ov_s !== 1'b1 || ow_s !== 32'h0200_0005) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL stall_hold: %0d cycles not holding 02000005 want 0", bad);
    end
    bus.out_ready = 1'b1;
    drain(50, to);
    tests++;
    if (to || sb_errs() != 0) begin
      fails++;
      $display("FAIL stall_data: count=%0d bad=%0d want 16 0",
               beats.size(), sb_errs());
    end
    tests++;
    if (beats.size() == 16 && beats[5].cyc != beats[4].cyc + 4) begin
      fails++;
      $display("FAIL stall_gap: beat5 cyc=%0d want %0d",
               beats[5].cyc, beats[4].cyc + 4);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int n;
    do_reset();
    bus.out_ready = 1'b0;
    bus.load_valid = 4'b0001;
    step();
    bus.load_valid = 4'b0010;
    step();
    bus.load_valid = 4'b0100;
    step();
    bus.load_valid = '0;
    bus.out_ready = 1'b1;
    n = 0;
    while (beats.size() < 7 && n < 50) begin
      step();
      n++;
    end
    tests++;
    if (beats.size() != 7 || ov_s !== 1'b1) begin
      fails++;
      $display("FAIL rmid_reach: beats=%0d valid=%b want 7 1",
               beats.size(), ov_s);
    end
    reset = 1'b1;
    bus.out_ready = 1'b0;
    step();
    reset = 1'b0;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL rmid_clear: valid=%b busy=%b want 0 0",
               bus.out_valid, bus.busy);
    end
    beats.delete();
    accs.delete();
    bus.load_valid = 4'b1111;
    bus.out_ready = 1'b1;
    step();
    tests++;
    if (rdy_s !== 4'b0001) begin
      fails++;
      $display("FAIL rmid_grant: got %b want 0001", rdy_s);
    end
    bus.load_valid = '0;
    drain(60, to);
    tests++;
    if (to || beats.size() != 16) begin
      fails++;
      $display("FAIL rmid_count: got %0d timeout=%b want 16 0",
               beats.size(), to);
    end
    tests++;
    if (sb_errs() != 0 || (beats.size() > 0 && beats[0].ch != 0)) begin
      fails++;
      $display("FAIL rmid_data: bad=%0d want 0", sb_errs());
    end
  endtask

  initial begin
    bus.load_valid = '0;
    bus.out_ready = 1'b0;
    bus.data_type = '0;
    bus.cacheline = '0;
    test_reset();
    test_single();
    test_rr();
    test_full();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded limit");
    $fatal(1, "watchdog");
  end
endmodule
